// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//   Shares one SPI master between four requesters. It picks a winner round-robin,
//   drives the winner's word onto DI and issues a one-cycle start strobe. It then
//   follows the master's LOAD handshake and returns DO with a one-cycle ack. A
//   timer aborts any transfer whose LOAD handshake stalls, and a gap counter
//   spaces consecutive transfers apart.
//
// Ports
//   clk    in   system clock, rising edge
//   clr    in   asynchronous active-high reset
//   req    in   [3:0]    per-requester request level, held until ack
//   wdata  in   [4*M-1:0] requester i TX word at [i*M +: M]
//   st     out  one-cycle start strobe to the master
//   DI     out  [M-1:0]  registered TX word to the master
//   LOAD   in   master LOAD: high idle, low during transfer, high on completion
//   DO     in   [M-1:0]  master RX word, valid from LOAD rising
//   sel    out  [3:0]    one-hot bus owner during a transaction
//   ack    out  [3:0]    one-cycle completion pulse to the owner
//   err    out  one-cycle abort flag, coincident with ack
//   rdata  out  [M-1:0]  last successfully received word
//   busy   out  high whenever not idle
module spi_txn_arbiter #(
    parameter int unsigned M    = 16,
    parameter int unsigned TOUT = 4096,
    parameter int unsigned GAP  = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [3:0]       req,
    input  logic [4*M-1:0]   wdata,
    output logic             st,
    output logic [M-1:0]     DI,
    input  logic             LOAD,
    input  logic [M-1:0]     DO,
    output logic [3:0]       sel,
    output logic [3:0]       ack,
    output logic             err,
    output logic [M-1:0]     rdata,
    output logic             busy
);

    localparam int unsigned TimerW = (TOUT > 1) ? $clog2(TOUT) : 1;
    localparam int unsigned GapW   = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TOUT - 1);
    localparam logic [GapW-1:0]   GapLast   = GapW'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitLo,
        StWaitHi,
        StDone,
        StAbort,
        StGap
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [3:0]         sel_q, sel_d;
    logic [M-1:0]       di_q, di_d;
    logic [M-1:0]       rdata_q, rdata_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [GapW-1:0]    gap_q, gap_d;

    // Round-robin pick: first set request scanning ptr, ptr+1, ... mod 4.
    logic [1:0] scan_idx;
    logic [1:0] pick;
    logic       found;

    always_comb begin
        scan_idx = ptr_q;
        pick     = ptr_q;
        found    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        di_d    = di_q;
        rdata_d = rdata_q;
        timer_d = timer_q;
        gap_d   = gap_q;

        case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d   = pick;
                    di_d    = wdata[32'(pick) * M +: M];
                    sel_d   = 4'b0001 << pick;
                    state_d = StStart;
                end
            end
            StStart: begin
                timer_d = '0;
                state_d = StWaitLo;
            end
            StWaitLo: begin
                if (!LOAD) begin
                    timer_d = '0;
                    state_d = StWaitHi;
                end else if (timer_q == TimerLast) begin
                    state_d = StAbort;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StWaitHi: begin
                if (LOAD) begin
                    rdata_d = DO;
                    state_d = StDone;
                end else if (timer_q == TimerLast) begin
                    state_d = StAbort;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StDone, StAbort: begin
                ptr_d   = gnt_q + 2'd1;
                sel_d   = '0;
                gap_d   = '0;
                state_d = (GAP > 0) ? StGap : StIdle;
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            di_q    <= '0;
            rdata_q <= '0;
            timer_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            di_q    <= di_d;
            rdata_q <= rdata_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
        end
    end

    // Outputs decode straight from registered state, so they are glitch-free
    // and drop to zero the moment clr asserts.
    always_comb begin
        st    = (state_q == StStart);
        busy  = (state_q != StIdle);
        err   = (state_q == StAbort);
        ack   = ((state_q == StDone) || (state_q == StAbort)) ? (4'b0001 << gnt_q) : 4'b0000;
        sel   = sel_q;
        DI    = di_q;
        rdata = rdata_q;
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
module tb_spi_txn_arbiter;

    localparam int unsigned M    = 16;
    localparam int unsigned TOUT = 16;
    localparam int unsigned GAP  = 8;

    logic          clk = 1'b0;
    logic          clr;
    logic [3:0]    req;
    logic [4*M-1:0] wdata;
    logic          st;
    logic [M-1:0]  DI;
    logic          LOAD;
    logic [M-1:0]  DO;
    logic [3:0]    sel;
    logic [3:0]    ack;
    logic          err;
    logic [M-1:0]  rdata;
    logic          busy;

    int checks = 0;
    int errors = 0;

    spi_txn_arbiter #(.M(M), .TOUT(TOUT), .GAP(GAP)) dut (
        .clk   (clk),
        .clr   (clr),
        .req   (req),
        .wdata (wdata),
        .st    (st),
        .DI    (DI),
        .LOAD  (LOAD),
        .DO    (DO),
        .sel   (sel),
        .ack   (ack),
        .err   (err),
        .rdata (rdata),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'b0001 << i;
    endfunction

    function automatic logic [15:0] word(input int i);
        logic [63:0] w;
        w = wdata;
        return w[i*16 +: 16];
    endfunction

    // Advance until st is high (at most 200 cycles); n = cycles advanced.
    task automatic wait_st(input string tag, output int n);
        n = 0;
        while (st !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(st), 64'd1);
    endtask

    // Advance until any ack bit is high (at most 200 cycles).
    task automatic wait_ack(input string tag, output int n);
        n = 0;
        while (ack === 4'b0000 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(ack != 4'b0000), 64'd1);
    endtask

    // From the START cycle: LOAD low 3 cycles after st, high hi_cyc later with dval.
    task automatic serve(input int hi_cyc, input logic [15:0] dval);
        repeat (3) tick();
        LOAD = 1'b0;
        repeat (hi_cyc) tick();
        DO   = dval;
        LOAD = 1'b1;
    endtask

    int n;
    logic [15:0] dval;

    initial begin
        clr   = 1'b1;
        req   = 4'b0000;
        LOAD  = 1'b1;
        DO    = '0;
        wdata = {16'h3D3D, 16'h2C2C, 16'h1B1B, 16'hA55A};
        tick();
        tick();
        chk("rst_st", 64'(st), 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_di", 64'(DI), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        clr = 1'b0;
        tick();

        // Single request. LOAD-high delay kept below the 16-cycle timeout.
        req = 4'b0001;
        tick();
        chk("t1_st", 64'(st), 64'd1);
        chk("t1_di", 64'(DI), 64'hA55A);
        chk("t1_sel", 64'(sel), 64'h1);
        chk("t1_busy", 64'(busy), 64'd1);
        tick();
        chk("t1_st_one_cycle", 64'(st), 64'd0);
        tick();
        tick();
        LOAD = 1'b0;
        repeat (10) tick();
        DO   = 16'h1234;
        LOAD = 1'b1;
        wait_ack("t1_ack_seen", n);
        chk("t1_ack_latency", 64'(n), 64'd1);
        chk("t1_ack", 64'(ack), 64'h1);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_rdata", 64'(rdata), 64'h1234);
        req = 4'b0000;
        tick();
        chk("t1_ack_one_cycle", 64'(ack), 64'd0);
        chk("t1_sel_clear", 64'(sel), 64'd0);

        // Round-robin from a fresh pointer: 0,1,2,3,0.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_st("rr_st_seen", n);
            if (i > 0) chk("rr_spacing", 64'(n >= int'(GAP) + 2), 64'd1);
            chk("rr_sel", 64'(sel), 64'(oh(i % 4)));
            chk("rr_di", 64'(DI), 64'(word(i % 4)));
            dval = 16'hC000 | 16'(i);
            serve(5, dval);
            wait_ack("rr_ack_seen", n);
            chk("rr_ack", 64'(ack), 64'(oh(i % 4)));
            chk("rr_rdata", 64'(rdata), 64'(dval));
            chk("rr_err", 64'(err), 64'd0);
        end
        req = 4'b0000;
        tick();

        // Timeout: LOAD never falls. ptr is 1, so requester 1 wins.
        req = 4'b0010;
        wait_st("to_st_seen", n);
        chk("to_sel", 64'(sel), 64'h2);
        wait_ack("to_ack_seen", n);
        chk("to_latency", 64'(n), 64'(TOUT + 1));
        chk("to_ack", 64'(ack), 64'h2);
        chk("to_err", 64'(err), 64'd1);
        chk("to_rdata_kept", 64'(rdata), 64'hC004);

        // Next requester after abort is 2; it drops req mid WAIT_HI.
        req = 4'b0101;
        wait_st("drop_st_seen", n);
        chk("drop_sel", 64'(sel), 64'h4);
        chk("drop_di", 64'(DI), 64'h2C2C);
        repeat (3) tick();
        LOAD = 1'b0;
        repeat (2) tick();
        req = 4'b0001;
        repeat (3) tick();
        DO   = 16'h7E7E;
        LOAD = 1'b1;
        wait_ack("drop_ack_seen", n);
        chk("drop_ack", 64'(ack), 64'h4);
        chk("drop_rdata", 64'(rdata), 64'h7E7E);
        wait_st("drop_next_st", n);
        chk("drop_next_sel", 64'(sel), 64'h1);
        serve(4, 16'h0F0F);
        wait_ack("drop_next_ack_seen", n);
        chk("drop_next_ack", 64'(ack), 64'h1);
        req = 4'b0000;

        // Wrap-around: 3 granted twice in a row.
        req = 4'b1000;
        wait_st("wrap_st1", n);
        chk("wrap_sel1", 64'(sel), 64'h8);
        serve(4, 16'h3333);
        wait_ack("wrap_ack1_seen", n);
        chk("wrap_ack1", 64'(ack), 64'h8);
        wait_st("wrap_st2", n);
        chk("wrap_sel2", 64'(sel), 64'h8);
        chk("wrap_di2", 64'(DI), 64'h3D3D);
        serve(4, 16'h4444);
        wait_ack("wrap_ack2_seen", n);
        chk("wrap_ack2", 64'(ack), 64'h8);
        chk("wrap_rdata2", 64'(rdata), 64'h4444);
        req = 4'b0100;
        wait_st("pre_rst_st", n);
        serve(4, 16'h5555);
        wait_ack("pre_rst_ack_seen", n);
        chk("pre_rst_ack", 64'(ack), 64'h4);
        req = 4'b0000;

        // Reset mid-transfer (ptr is 3 before reset, 0 after).
        req = 4'b1000;
        wait_st("mid_st_seen", n);
        repeat (3) tick();
        LOAD = 1'b0;
        repeat (3) tick();
        chk("mid_busy_before", 64'(busy), 64'd1);
        #2;
        clr = 1'b1;
        #1;
        chk("mid_st", 64'(st), 64'd0);
        chk("mid_sel", 64'(sel), 64'd0);
        chk("mid_ack", 64'(ack), 64'd0);
        chk("mid_err", 64'(err), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_di", 64'(DI), 64'd0);
        chk("mid_rdata", 64'(rdata), 64'd0);
        tick();
        clr  = 1'b0;
        LOAD = 1'b1;
        req  = 4'b1010;
        wait_st("post_rst_st", n);
        chk("post_rst_sel", 64'(sel), 64'h2);
        chk("post_rst_di", 64'(DI), 64'h1B1B);
        serve(4, 16'h6666);
        wait_ack("post_rst_ack_seen", n);
        chk("post_rst_ack", 64'(ack), 64'h2);
        req = 4'b0000;

        // LOAD glitch while idle is ignored.
        repeat (12) tick();
        LOAD = 1'b0;
        tick();
        chk("glitch_busy", 64'(busy), 64'd0);
        LOAD = 1'b1;
        tick();
        chk("glitch_st", 64'(st), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
